// File: rtl/qpp_pkg.sv
// Shared definitions for the QPP turbo-code interleaver controller:
// FSM state encoding, default sizing constants and the LTE f1/f2 table.
package qpp_pkg;

    localparam int QPP_KMAX = 2560;
    localparam int QPP_AW   = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PERM = 2'd2
    } qpp_state_e;

    typedef struct packed {
        logic              valid;
        logic [QPP_AW-1:0] f1;
        logic [QPP_AW-1:0] f2;
    } qpp_param_t;

    function automatic qpp_param_t qp_entry(input int f1, input int f2);
        qpp_param_t p;
        p.valid = 1'b1;
        p.f1    = QPP_AW'(f1);
        p.f2    = QPP_AW'(f2);
        return p;
    endfunction

    // Block sizes 40..2560 of the LTE QPP parameter table; anything else is unsupported.
    function automatic qpp_param_t qpp_lookup(input logic [QPP_AW-1:0] k);
        qpp_param_t p;
        p = '0;
        case (k)
            12'd40:   p = qp_entry(3, 10);    12'd48:   p = qp_entry(7, 12);    12'd56:   p = qp_entry(19, 42);
            12'd64:   p = qp_entry(7, 16);    12'd72:   p = qp_entry(7, 18);    12'd80:   p = qp_entry(11, 20);
            12'd88:   p = qp_entry(5, 22);    12'd96:   p = qp_entry(11, 24);   12'd104:  p = qp_entry(7, 26);
            12'd112:  p = qp_entry(41, 84);   12'd120:  p = qp_entry(103, 90);  12'd128:  p = qp_entry(15, 32);
            12'd136:  p = qp_entry(9, 34);    12'd144:  p = qp_entry(17, 108);  12'd152:  p = qp_entry(9, 38);
            12'd160:  p = qp_entry(21, 120);  12'd168:  p = qp_entry(101, 84);  12'd176:  p = qp_entry(21, 44);
            12'd184:  p = qp_entry(57, 46);   12'd192:  p = qp_entry(23, 48);   12'd200:  p = qp_entry(13, 50);
            12'd208:  p = qp_entry(27, 52);   12'd216:  p = qp_entry(11, 36);   12'd224:  p = qp_entry(27, 56);
            12'd232:  p = qp_entry(85, 58);   12'd240:  p = qp_entry(29, 60);   12'd248:  p = qp_entry(33, 62);
            12'd256:  p = qp_entry(15, 32);   12'd264:  p = qp_entry(17, 198);  12'd272:  p = qp_entry(33, 68);
            12'd280:  p = qp_entry(103, 210); 12'd288:  p = qp_entry(19, 36);   12'd296:  p = qp_entry(19, 74);
            12'd304:  p = qp_entry(37, 76);   12'd312:  p = qp_entry(19, 78);   12'd320:  p = qp_entry(21, 120);
            12'd328:  p = qp_entry(21, 82);   12'd336:  p = qp_entry(115, 84);  12'd344:  p = qp_entry(193, 86);
            12'd352:  p = qp_entry(21, 44);   12'd360:  p = qp_entry(133, 90);  12'd368:  p = qp_entry(81, 46);
            12'd376:  p = qp_entry(45, 94);   12'd384:  p = qp_entry(23, 48);   12'd392:  p = qp_entry(243, 98);
            12'd400:  p = qp_entry(151, 40);  12'd408:  p = qp_entry(155, 102); 12'd416:  p = qp_entry(25, 52);
            12'd424:  p = qp_entry(51, 106);  12'd432:  p = qp_entry(47, 72);   12'd440:  p = qp_entry(91, 110);
            12'd448:  p = qp_entry(29, 168);  12'd456:  p = qp_entry(29, 114);  12'd464:  p = qp_entry(247, 58);
            12'd472:  p = qp_entry(29, 118);  12'd480:  p = qp_entry(89, 180);  12'd488:  p = qp_entry(91, 122);
            12'd496:  p = qp_entry(157, 62);  12'd504:  p = qp_entry(55, 84);   12'd512:  p = qp_entry(31, 64);
            12'd528:  p = qp_entry(17, 66);   12'd544:  p = qp_entry(35, 68);   12'd560:  p = qp_entry(227, 420);
            12'd576:  p = qp_entry(65, 96);   12'd592:  p = qp_entry(19, 74);   12'd608:  p = qp_entry(37, 76);
            12'd624:  p = qp_entry(41, 234);  12'd640:  p = qp_entry(39, 80);   12'd656:  p = qp_entry(185, 82);
            12'd672:  p = qp_entry(43, 252);  12'd688:  p = qp_entry(21, 86);   12'd704:  p = qp_entry(155, 44);
            12'd720:  p = qp_entry(79, 120);  12'd736:  p = qp_entry(139, 92);  12'd752:  p = qp_entry(23, 94);
            12'd768:  p = qp_entry(217, 48);  12'd784:  p = qp_entry(25, 98);   12'd800:  p = qp_entry(17, 80);
            12'd816:  p = qp_entry(127, 102); 12'd832:  p = qp_entry(25, 52);   12'd848:  p = qp_entry(239, 106);
            12'd864:  p = qp_entry(17, 48);   12'd880:  p = qp_entry(137, 110); 12'd896:  p = qp_entry(215, 112);
            12'd912:  p = qp_entry(29, 114);  12'd928:  p = qp_entry(15, 58);   12'd944:  p = qp_entry(147, 118);
            12'd960:  p = qp_entry(29, 60);   12'd976:  p = qp_entry(59, 122);  12'd992:  p = qp_entry(65, 124);
            12'd1008: p = qp_entry(55, 84);   12'd1024: p = qp_entry(31, 64);   12'd1056: p = qp_entry(17, 66);
            12'd1088: p = qp_entry(171, 204); 12'd1120: p = qp_entry(67, 140);  12'd1152: p = qp_entry(35, 72);
            12'd1184: p = qp_entry(19, 74);   12'd1216: p = qp_entry(39, 76);   12'd1248: p = qp_entry(19, 78);
            12'd1280: p = qp_entry(199, 240); 12'd1312: p = qp_entry(21, 82);   12'd1344: p = qp_entry(211, 252);
            12'd1376: p = qp_entry(21, 86);   12'd1408: p = qp_entry(43, 88);   12'd1440: p = qp_entry(149, 60);
            12'd1472: p = qp_entry(45, 92);   12'd1504: p = qp_entry(49, 846);  12'd1536: p = qp_entry(71, 48);
            12'd1568: p = qp_entry(13, 28);   12'd1600: p = qp_entry(17, 80);   12'd1632: p = qp_entry(25, 102);
            12'd1664: p = qp_entry(183, 104); 12'd1696: p = qp_entry(55, 954);  12'd1728: p = qp_entry(127, 96);
            12'd1760: p = qp_entry(27, 110);  12'd1792: p = qp_entry(29, 112);  12'd1824: p = qp_entry(29, 114);
            12'd1856: p = qp_entry(57, 116);  12'd1888: p = qp_entry(45, 354);  12'd1920: p = qp_entry(31, 120);
            12'd1952: p = qp_entry(59, 610);  12'd1984: p = qp_entry(185, 124); 12'd2016: p = qp_entry(113, 420);
            12'd2048: p = qp_entry(31, 64);   12'd2112: p = qp_entry(17, 66);   12'd2176: p = qp_entry(171, 136);
            12'd2240: p = qp_entry(209, 420); 12'd2304: p = qp_entry(253, 216); 12'd2368: p = qp_entry(367, 444);
            12'd2432: p = qp_entry(265, 456); 12'd2496: p = qp_entry(181, 468); 12'd2560: p = qp_entry(39, 80);
            default:  p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/qpp_param_rom.sv
// Combinational block-size -> (f1, f2, valid) lookup. Sizes above KMAX are
// reported as unsupported even if the table knows them.
module qpp_param_rom
    import qpp_pkg::*;
#(
    parameter int KMAX = QPP_KMAX,
    parameter int AW   = QPP_AW
) (
    input  logic [AW-1:0] k,
    output logic [AW-1:0] f1,
    output logic [AW-1:0] f2,
    output logic          valid
);

    qpp_param_t entry;
    logic       in_range;

    // Range-check k against KMAX and the table width, then look up f1/f2.
    always_comb begin
        in_range = (int'(k) <= KMAX) && (int'(k) < (1 << QPP_AW));
        entry    = qpp_lookup(QPP_AW'(k));
        valid    = in_range && entry.valid;
        f1       = AW'(entry.f1);
        f2       = AW'(entry.f2);
    end

endmodule

// File: rtl/qpp_interleave_ctrl.sv
// QPP interleaver controller: loads K bits in natural order into a bit buffer,
// then streams them out in QPP order pi(j) = (f1*j + f2*j*j) mod K.
// pi is generated incrementally (pi += g, g += 2*f2), every step mod K by one
// compare-and-subtract, so no multiplier or divider sits in the address path.
//
// Handshake: a beat moves on in_valid && in_ready (resp. out_valid && out_ready)
// at the rising clock edge; a valid source holds its data until that beat, and
// ready may be observed before valid without any combinational loop.
module qpp_interleave_ctrl
    import qpp_pkg::*;
#(
    parameter int KMAX = QPP_KMAX,
    parameter int AW   = QPP_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] k_in,
    input  logic          in_valid,
    input  logic          in_bit,
    output logic          in_ready,
    output logic          out_valid,
    output logic          out_bit,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int IW = $clog2(KMAX);

    qpp_state_e    state_q, state_d;
    logic [AW-1:0] k_q, f1_q, f2_q, d_q;
    logic [AW-1:0] i_q, pi_q, g_q;
    logic          err_q;
    logic          buffer [KMAX];

    logic [AW-1:0] rom_f1, rom_f2;
    logic          rom_valid;
    logic          last_idx;

    // a + b mod m, valid only for a, b < m
    function automatic logic [AW-1:0] add_mod(input logic [AW-1:0] a,
                                               input logic [AW-1:0] b,
                                               input logic [AW-1:0] m);
        logic [AW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, m}) s = s - {1'b0, m};
        return s[AW-1:0];
    endfunction

    qpp_param_rom #(.KMAX(KMAX), .AW(AW)) u_rom (
        .k     (k_in),
        .f1    (rom_f1),
        .f2    (rom_f2),
        .valid (rom_valid)
    );

    // i counts input writes in LOAD and output transfers in PERM.
    assign last_idx = (i_q == k_q - AW'(1));
    assign busy     = (state_q != ST_IDLE);
    assign err      = err_q;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_bit   = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && rom_valid) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && last_idx) state_d = ST_PERM;
            end
            ST_PERM: begin
                out_valid = 1'b1;
                out_bit   = buffer[IW'(pi_q)];
                if (out_ready && last_idx) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Block parameters, counters and the QPP address recurrence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q   <= '0;
            f1_q  <= '0;
            f2_q  <= '0;
            d_q   <= '0;
            i_q   <= '0;
            pi_q  <= '0;
            g_q   <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    err_q <= start && !rom_valid;
                    if (start && rom_valid) begin
                        k_q  <= k_in;
                        f1_q <= rom_f1;
                        f2_q <= rom_f2;
                        d_q  <= add_mod(rom_f2, rom_f2, k_in);
                        i_q  <= '0;
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        if (last_idx) begin
                            i_q  <= '0;
                            pi_q <= '0;
                            g_q  <= add_mod(f1_q, f2_q, k_q);
                        end else begin
                            i_q <= i_q + AW'(1);
                        end
                    end
                end
                ST_PERM: begin
                    if (out_ready) begin
                        pi_q <= add_mod(pi_q, g_q, k_q);
                        g_q  <= add_mod(g_q, d_q, k_q);
                        i_q  <= last_idx ? '0 : i_q + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Natural-order bit buffer; contents are don't-care across reset.
    always_ff @(posedge clk) begin
        if (state_q == ST_LOAD && in_valid) buffer[IW'(i_q)] <= in_bit;
    end

endmodule
